// File: rtl/muli_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : muli_if                                                      |
// | Description : Handshake/data bundle for the muli sequential multiplier.    |
// |               master drives start/a/b and observes the result;             |
// |               slave (the multiplier) drives busy/done/valid/ovf/val.       |
// | Ports       : start, a, b            (master -> slave)                     |
// |               busy, done, valid, ovf, val (slave -> master)                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface muli_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             busy;
  logic             done;
  logic             valid;
  logic             ovf;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] val;

  modport master (
    output start, a, b,
    input  busy, done, valid, ovf, val
  );

  modport slave (
    input  start, a, b,
    output busy, done, valid, ovf, val
  );
endinterface
`default_nettype wire

// File: rtl/muli.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : muli                                                         |
// | Description : Sequential signed fixed-point multiplier, shift-add with one |
// |               partial product per clock, round-half-to-even on the         |
// |               discarded fractional bits. start/busy/done/valid/ovf         |
// |               handshake identical to the divi divider.                     |
// | Parameters  : WIDTH - operand/result width (two's complement)              |
// |               FBITS - fractional bits within WIDTH, 0 <= FBITS < WIDTH     |
// | Ports       : clk  - clock, rising edge                                    |
// |               rst  - asynchronous reset, active low                        |
// |               bus  - muli_if.slave: start, a, b in; busy, done, valid,     |
// |                      ovf, val out                                          |
// | Macro       : MULI_SAT_EN - when defined, overflow saturates val to the    |
// |               largest/smallest code and reports valid=1 along with ovf.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module muli #(
  parameter int WIDTH = 8,
  parameter int FBITS = 4
) (
  input  logic   clk,
  input  logic   rst,
  muli_if.slave  bus
);

  localparam int WIDTHU = WIDTH - 1;
  localparam int PW     = 2 * WIDTHU;
  localparam int IW     = (WIDTHU > 1) ? $clog2(WIDTHU) : 1;

  localparam logic [WIDTH-1:0] c_smallest = {1'b1, {WIDTHU{1'b0}}};
  localparam logic [WIDTH-1:0] c_largest  = {1'b0, {WIDTHU{1'b1}}};
  localparam logic [IW-1:0]    c_last_bit = IW'(WIDTHU - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_CALC  = 3'd2,
    S_ROUND = 3'd3,
    S_SIGN  = 3'd4
  } state_t;

  state_t            r_state;
  logic [WIDTHU-1:0] r_au;
  logic [WIDTHU-1:0] r_bu;
  logic              r_sig_diff;
  logic [PW-1:0]     r_prod;
  logic [IW-1:0]     r_i;

  logic              r_busy;
  logic              r_done;
  logic              r_valid;
  logic              r_ovf;
  logic [WIDTH-1:0]  r_val;

  // ---------------------------------------------------------------------------
  // Operand decode (IDLE only). Magnitudes are only captured for operands that
  // are not SMALLEST, so the low WIDTHU bits of the two's complement negation
  // hold the full magnitude.
  // ---------------------------------------------------------------------------
  logic              w_a_sign;
  logic              w_b_sign;
  logic [WIDTHU-1:0] w_au;
  logic [WIDTHU-1:0] w_bu;
  logic              w_any_zero;
  logic              w_any_smallest;

  assign w_a_sign       = bus.a[WIDTH-1];
  assign w_b_sign       = bus.b[WIDTH-1];
  assign w_au           = w_a_sign ? (~bus.a[WIDTHU-1:0] + 1'b1) : bus.a[WIDTHU-1:0];
  assign w_bu           = w_b_sign ? (~bus.b[WIDTHU-1:0] + 1'b1) : bus.b[WIDTHU-1:0];
  assign w_any_zero     = (bus.a == '0) || (bus.b == '0);
  assign w_any_smallest = (bus.a == c_smallest) || (bus.b == c_smallest);

  // Partial product for the current multiplier bit.
  logic [PW-1:0] w_addend;
  assign w_addend = PW'(r_bu) << r_i;

  // ---------------------------------------------------------------------------
  // Rounding: drop FBITS fractional bits of the full product, round half to
  // even. For FBITS>0 the incremented quotient cannot exceed PW bits because
  // the shifted value is at most PW-FBITS bits wide.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] w_rounded;

  generate
    if (FBITS == 0) begin : g_round_none
      assign w_rounded = r_prod;
    end else begin : g_round_even
      localparam logic [PW-1:0] c_sticky_mask = (PW'(1) << (FBITS - 1)) - PW'(1);
      logic [PW-1:0] w_q;
      logic          w_round_bit;
      logic          w_sticky;
      assign w_q         = r_prod >> FBITS;
      assign w_round_bit = r_prod[FBITS-1];
      assign w_sticky    = |(r_prod & c_sticky_mask);
      // Exact ties go to the even neighbour; anything above the tie rounds up.
      assign w_rounded   = w_q + PW'(w_round_bit && (w_sticky || w_q[0]));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Sign application on the rounded magnitude held in r_prod.
  // The magnitude is at most 2**WIDTHU-1, so a negative result never reaches
  // SMALLEST and a zero magnitude is never negated.
  // ---------------------------------------------------------------------------
  logic              w_res_ovf;
  logic [WIDTHU-1:0] w_mag;
  logic [WIDTH-1:0]  w_signed;

  assign w_res_ovf = |r_prod[PW-1:WIDTHU];
  assign w_mag     = r_prod[WIDTHU-1:0];
  assign w_signed  = (r_sig_diff && (w_mag != '0)) ? (-{1'b0, w_mag}) : {1'b0, w_mag};

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_au       <= '0;
      r_bu       <= '0;
      r_sig_diff <= 1'b0;
      r_prod     <= '0;
      r_i        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
      r_val      <= '0;
    end else begin
      // done is a single-cycle strobe
      r_done <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_valid <= 1'b0;
            if (w_any_zero) begin
              // Zero takes priority over SMALLEST: 0 * SMALLEST is exactly 0.
              r_done  <= 1'b1;
              r_val   <= '0;
              r_valid <= 1'b1;
              r_ovf   <= 1'b0;
            end else if (w_any_smallest) begin
              // |SMALLEST| has no WIDTHU-bit magnitude; any nonzero product
              // with it is reported as overflow straight away.
              r_done <= 1'b1;
              r_ovf  <= 1'b1;
`ifdef MULI_SAT_EN
              r_valid <= 1'b1;
              r_val   <= (w_a_sign ^ w_b_sign) ? c_smallest : c_largest;
`endif
            end else begin
              r_au       <= w_au;
              r_bu       <= w_bu;
              r_sig_diff <= w_a_sign ^ w_b_sign;
              r_busy     <= 1'b1;
              r_ovf      <= 1'b0;
              r_state    <= S_INIT;
            end
          end
        end

        S_INIT: begin
          r_prod  <= '0;
          r_i     <= '0;
          r_state <= S_CALC;
        end

        S_CALC: begin
          // LSB-first over the WIDTHU magnitude bits of the multiplicand.
          if (r_au[r_i]) begin
            r_prod <= r_prod + w_addend;
          end
          r_i <= r_i + 1'b1;
          if (r_i == c_last_bit) begin
            r_state <= S_ROUND;
          end
        end

        S_ROUND: begin
          r_prod  <= w_rounded;
          r_state <= S_SIGN;
        end

        S_SIGN: begin
          if (w_res_ovf) begin
            r_ovf <= 1'b1;
`ifdef MULI_SAT_EN
            r_valid <= 1'b1;
            r_val   <= r_sig_diff ? c_smallest : c_largest;
`endif
          end else begin
            r_val   <= w_signed;
            r_valid <= 1'b1;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.valid = r_valid;
  assign bus.ovf   = r_ovf;
  assign bus.val   = r_val;

endmodule
`default_nettype wire

// File: tb/tb_muli.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_muli                                                      |
// | Description : Directed self-checking bench for muli (WIDTH=8, FBITS=4).    |
// |               Expected results are hand-computed Q3.4 products.            |
// | Macro       : MULI_SAT_EN selects the saturating overflow expectations.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_muli;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  muli_if #(.WIDTH(8)) bus ();

  muli #(
    .WIDTH(8),
    .FBITS(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation; lat = edges after the start-sampling edge until done
  // is seen (0 for fast paths), -1 on timeout. busy_ok drops if busy was low
  // at any sample before done.
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib,
                       output int lat, output bit busy_ok);
    @(negedge clk);
    bus.a     = ia;
    bus.b     = ib;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat       = -1;
    busy_ok   = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      if (bus.done) begin
        lat = k;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    #2;
    checks++;
    if ({bus.busy, bus.done, bus.valid, bus.ovf, bus.val} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=000", {bus.busy, bus.done, bus.valid, bus.ovf, bus.val});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    bit bok;
    do_op(8'h18, 8'h20, lat, bok);
    checks++;
    if (lat !== 10) begin errors++; $display("FAIL basic_latency got=%0d exp=10", lat); end
    checks++;
    if (bok !== 1'b1) begin errors++; $display("FAIL basic_busy got=%0b exp=1", bok); end
    checks++;
    if ({bus.valid, bus.ovf, bus.val} !== {1'b1, 1'b0, 8'h30}) begin
      errors++; $display("FAIL basic_pos got v=%0b o=%0b val=%h exp v=1 o=0 val=30", bus.valid, bus.ovf, bus.val);
    end
    do_op(8'hE8, 8'h20, lat, bok);
    checks++;
    if ({bus.valid, bus.ovf, bus.val} !== {1'b1, 1'b0, 8'hD0} || lat !== 10) begin
      errors++; $display("FAIL basic_neg got v=%0b o=%0b val=%h lat=%0d exp v=1 o=0 val=d0 lat=10", bus.valid, bus.ovf, bus.val, lat);
    end
    do_op(8'hE8, 8'hE0, lat, bok);
    checks++;
    if ({bus.valid, bus.ovf, bus.val} !== {1'b1, 1'b0, 8'h30}) begin
      errors++; $display("FAIL basic_negneg got v=%0b o=%0b val=%h exp v=1 o=0 val=30", bus.valid, bus.ovf, bus.val);
    end
  endtask

  task automatic test_rounding();
    logic [7:0] ta [8] = '{8'h01, 8'h03, 8'h03, 8'hFD, 8'hFF, 8'h7F, 8'h81, 8'h28};
    logic [7:0] tb [8] = '{8'h08, 8'h08, 8'h09, 8'h08, 8'h08, 8'h10, 8'h10, 8'h0C};
    logic [7:0] te [8] = '{8'h00, 8'h02, 8'h02, 8'hFE, 8'h00, 8'h7F, 8'h81, 8'h1E};
    int lat;
    bit bok;
    for (int n = 0; n < 8; n++) begin
      do_op(ta[n], tb[n], lat, bok);
      checks++;
      if ({bus.valid, bus.ovf, bus.val} !== {1'b1, 1'b0, te[n]} || lat !== 10) begin
        errors++;
        $display("FAIL round_%0d a=%h b=%h got v=%0b o=%0b val=%h lat=%0d exp v=1 o=0 val=%h lat=10",
                 n, ta[n], tb[n], bus.valid, bus.ovf, bus.val, lat, te[n]);
      end
    end
  endtask

  task automatic test_overflow();
    int lat;
    bit bok;
    do_op(8'h18, 8'h20, lat, bok);  // leaves val=0x30
    do_op(8'h40, 8'h30, lat, bok);
    checks++;
`ifdef MULI_SAT_EN
    if ({bus.valid, bus.ovf, bus.val} !== {1'b1, 1'b1, 8'h7F} || lat !== 10) begin
      errors++; $display("FAIL ovf_pos got v=%0b o=%0b val=%h lat=%0d exp v=1 o=1 val=7f lat=10", bus.valid, bus.ovf, bus.val, lat);
    end
`else
    if ({bus.valid, bus.ovf, bus.val} !== {1'b0, 1'b1, 8'h30} || lat !== 10) begin
      errors++; $display("FAIL ovf_pos got v=%0b o=%0b val=%h lat=%0d exp v=0 o=1 val=30 lat=10", bus.valid, bus.ovf, bus.val, lat);
    end
`endif
    do_op(8'hC0, 8'h30, lat, bok);
    checks++;
`ifdef MULI_SAT_EN
    if ({bus.valid, bus.ovf, bus.val} !== {1'b1, 1'b1, 8'h80}) begin
      errors++; $display("FAIL ovf_neg got v=%0b o=%0b val=%h exp v=1 o=1 val=80", bus.valid, bus.ovf, bus.val);
    end
`else
    if ({bus.valid, bus.ovf, bus.val} !== {1'b0, 1'b1, 8'h30}) begin
      errors++; $display("FAIL ovf_neg got v=%0b o=%0b val=%h exp v=0 o=1 val=30", bus.valid, bus.ovf, bus.val);
    end
`endif
    do_op(8'h7F, 8'h7F, lat, bok);
    checks++;
    if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_max got o=%0b exp o=1", bus.ovf); end
    // next accepted start clears ovf
    do_op(8'h18, 8'h20, lat, bok);
    checks++;
    if ({bus.valid, bus.ovf, bus.val} !== {1'b1, 1'b0, 8'h30}) begin
      errors++; $display("FAIL ovf_clear got v=%0b o=%0b val=%h exp v=1 o=0 val=30", bus.valid, bus.ovf, bus.val);
    end
  endtask

  task automatic test_fast_paths();
    int lat;
    bit bok;
    do_op(8'h00, 8'h55, lat, bok);
    checks++;
    if ({bus.valid, bus.ovf, bus.val} !== {1'b1, 1'b0, 8'h00} || lat !== 0) begin
      errors++; $display("FAIL fast_zero got v=%0b o=%0b val=%h lat=%0d exp v=1 o=0 val=00 lat=0", bus.valid, bus.ovf, bus.val, lat);
    end
    do_op(8'h18, 8'h20, lat, bok);  // val=0x30 for the next check
    do_op(8'h80, 8'h10, lat, bok);
    checks++;
`ifdef MULI_SAT_EN
    if ({bus.valid, bus.ovf, bus.val} !== {1'b1, 1'b1, 8'h80} || lat !== 0) begin
      errors++; $display("FAIL fast_smallest got v=%0b o=%0b val=%h lat=%0d exp v=1 o=1 val=80 lat=0", bus.valid, bus.ovf, bus.val, lat);
    end
`else
    if ({bus.valid, bus.ovf, bus.val} !== {1'b0, 1'b1, 8'h30} || lat !== 0) begin
      errors++; $display("FAIL fast_smallest got v=%0b o=%0b val=%h lat=%0d exp v=0 o=1 val=30 lat=0", bus.valid, bus.ovf, bus.val, lat);
    end
`endif
    // zero wins over SMALLEST
    do_op(8'h80, 8'h00, lat, bok);
    checks++;
    if ({bus.valid, bus.ovf, bus.val} !== {1'b1, 1'b0, 8'h00} || lat !== 0) begin
      errors++; $display("FAIL fast_zero_smallest got v=%0b o=%0b val=%h lat=%0d exp v=1 o=0 val=00 lat=0", bus.valid, bus.ovf, bus.val, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit bok;
    do_op(8'h03, 8'h08, lat, bok);
    @(posedge clk);
    #1;
    checks++;
    if ({bus.done, bus.valid, bus.val} !== {1'b0, 1'b1, 8'h02}) begin
      errors++; $display("FAIL b2b_done_width got d=%0b v=%0b val=%h exp d=0 v=1 val=02", bus.done, bus.valid, bus.val);
    end
    do_op(8'hE8, 8'h20, lat, bok);
    checks++;
    if (bus.val !== 8'hD0 || lat !== 10) begin
      errors++; $display("FAIL b2b_second got val=%h lat=%0d exp val=d0 lat=10", bus.val, lat);
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    lat = -1;
    @(negedge clk);
    bus.a = 8'h18; bus.b = 8'h20; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    // new start and changed operands while busy
    @(negedge clk);
    bus.a = 8'h40; bus.b = 8'h30; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 8'h00;
    for (int k = 6; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin lat = k; break; end
    end
    checks++;
    if ({bus.valid, bus.ovf, bus.val} !== {1'b1, 1'b0, 8'h30} || lat !== 10) begin
      errors++; $display("FAIL start_ignored got v=%0b o=%0b val=%h lat=%0d exp v=1 o=0 val=30 lat=10", bus.valid, bus.ovf, bus.val, lat);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++; $display("FAIL start_ignored_idle got busy=%0b done=%0b exp 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit bok;
    bit seen_done;
    do_op(8'h18, 8'h20, lat, bok);
    @(negedge clk);
    bus.a = 8'h03; bus.b = 8'h09; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.valid, bus.ovf, bus.val} !== 12'h000) begin
      errors++; $display("FAIL reset_mid_outputs got=%h exp=000", {bus.busy, bus.done, bus.valid, bus.ovf, bus.val});
    end
    @(negedge clk);
    rst = 1'b1;
    seen_done = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++; $display("FAIL reset_mid_abort got activity=%0b exp 0", seen_done);
    end
    do_op(8'hE8, 8'hE0, lat, bok);
    checks++;
    if ({bus.valid, bus.ovf, bus.val} !== {1'b1, 1'b0, 8'h30} || lat !== 10) begin
      errors++; $display("FAIL reset_mid_next got v=%0b o=%0b val=%h lat=%0d exp v=1 o=0 val=30 lat=10", bus.valid, bus.ovf, bus.val, lat);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_rounding();
    test_overflow();
    test_fast_paths();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
